// File: rtl/hdr_frame_sequencer_if.sv
// Handshake and status bundle between the CCC handler and the HDR-DDR frame sequencer.
// Signal names match the original flat port list so the bundle can be connected one-to-one.
interface hdr_frame_sequencer_if #(
  parameter int unsigned LEN_W = 16
);
  logic             i_seq_start;
  logic             i_seq_abort;
  logic             i_regf_CMD_ATTR;
  logic [LEN_W-1:0] i_regf_DATA_LEN;
  logic [2:0]       i_regf_DTT;
  logic             i_bit_tick;
  logic [5:0]       i_cnt_bit_count;
  logic             o_seq_busy;
  logic             o_byte_strobe;
  logic             o_last_frame;
  logic             o_crc_phase;
  logic             o_seq_done;
  logic             o_seq_err;
  logic [LEN_W-1:0] o_bytes_left;

  modport master (
    output i_seq_start, i_seq_abort, i_regf_CMD_ATTR, i_regf_DATA_LEN, i_regf_DTT,
           i_bit_tick, i_cnt_bit_count,
    input  o_seq_busy, o_byte_strobe, o_last_frame, o_crc_phase, o_seq_done,
           o_seq_err, o_bytes_left
  );

  modport slave (
    input  i_seq_start, i_seq_abort, i_regf_CMD_ATTR, i_regf_DATA_LEN, i_regf_DTT,
           i_bit_tick, i_cnt_bit_count,
    output o_seq_busy, o_byte_strobe, o_last_frame, o_crc_phase, o_seq_done,
           o_seq_err, o_bytes_left
  );
endinterface

// File: rtl/hdr_frame_sequencer.sv
// HDR-DDR data-phase sequencer: sizes the transfer from the command descriptor and
// tracks byte boundaries from the bit counter, with optional trailing CRC word.
module hdr_frame_sequencer #(
    parameter int unsigned LEN_W       = 16,
    parameter bit          CRC_WORD_EN = 1'b1
) (
    input logic                  i_fcnt_clk,
    input logic                  i_fcnt_rst_n,
    hdr_frame_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DATA,
        S_CRC,
        S_DONE
    } state_t;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state;
    logic             cmd_attr;
    logic [LEN_W-1:0] data_len;
    logic [2:0]       dtt;

    logic             busy;
    logic             strobe;
    logic             last;
    logic             crc;
    logic             done;
    logic             err;
    logic [LEN_W-1:0] left;

    logic             bb;
    logic             bb_word_end;
    logic             dtt_reserved;
    logic [LEN_W-1:0] load_cnt;
    logic [LEN_W-1:0] left_dec;

    // Byte boundaries fall at the half-word (bit 9) and word end (bit 19).
    assign bb           = bus.i_bit_tick &&
                          ((bus.i_cnt_bit_count == 6'd9) || (bus.i_cnt_bit_count == 6'd19));
    assign bb_word_end  = bus.i_bit_tick && (bus.i_cnt_bit_count == 6'd19);
    assign dtt_reserved = cmd_attr && dtt[2] && (dtt[1] || dtt[0]);
    assign load_cnt     = cmd_attr ? {{(LEN_W-3){1'b0}}, dtt} : data_len;
    assign left_dec     = left - ONE;

    always_ff @(posedge i_fcnt_clk or negedge i_fcnt_rst_n) begin
        if (!i_fcnt_rst_n) begin
            state    <= S_IDLE;
            cmd_attr <= 1'b0;
            data_len <= '0;
            dtt      <= '0;
            busy     <= 1'b0;
            strobe   <= 1'b0;
            last     <= 1'b0;
            crc      <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            left     <= '0;
        end else begin
            strobe <= 1'b0;
            done   <= 1'b0;
            // Abort outranks any boundary seen in the same cycle; the error flag is left alone.
            if ((state != S_IDLE) && bus.i_seq_abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                left  <= '0;
                last  <= 1'b0;
                crc   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (bus.i_seq_start) begin
                            cmd_attr <= bus.i_regf_CMD_ATTR;
                            data_len <= bus.i_regf_DATA_LEN;
                            dtt      <= bus.i_regf_DTT;
                            err      <= 1'b0;
                            busy     <= 1'b1;
                            state    <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        if (dtt_reserved) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            left <= load_cnt;
                            last <= (load_cnt == ONE);
                            if (load_cnt == '0) begin
                                if (CRC_WORD_EN) begin
                                    crc   <= 1'b1;
                                    state <= S_CRC;
                                end else begin
                                    done  <= 1'b1;
                                    state <= S_DONE;
                                end
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (bb && (left != '0)) begin
                            strobe <= 1'b1;
                            left   <= left_dec;
                            last   <= (left_dec == ONE);
                            if (left_dec == '0) begin
                                if (CRC_WORD_EN) begin
                                    crc   <= 1'b1;
                                    state <= S_CRC;
                                end else begin
                                    done  <= 1'b1;
                                    state <= S_DONE;
                                end
                            end
                        end
                    end
                    S_CRC: begin
                        if (bb_word_end) begin
                            crc   <= 1'b0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.o_seq_busy    = busy;
    assign bus.o_byte_strobe = strobe;
    assign bus.o_last_frame  = last;
    assign bus.o_crc_phase   = crc;
    assign bus.o_seq_done    = done;
    assign bus.o_seq_err     = err;
    assign bus.o_bytes_left  = left;

endmodule

// File: doc/hdr_frame_sequencer.md
Name: hdr_frame_sequencer

Overview:
- Synchronous controller that sequences the HDR-DDR data phase of a CCC/private transfer in the CCC handler.
- Sizes the transfer from the command descriptor: regular commands use DATA_LEN, immediate commands use DTT.
- Tracks byte boundaries reported by the bit counter and drives per-byte, last-byte, CRC-phase and done indications to the TX/RX datapath.
- Replaces free-running frame counting with an explicit, handshaked state machine clocked by the system clock.

Parameters:
- LEN_W, 16, width of the byte-count datapath; must be at least 16.
- CRC_WORD_EN, 1, 1 = append one 20-bit CRC word phase after data; 0 = finish directly after the last byte.

Ports:
- i_fcnt_clk  input  1  system clock, rising edge.
- i_fcnt_rst_n  input  1  reset, asynchronous, active-low.
- i_seq_start  input  1  1-cycle pulse; latches the descriptor and starts a transfer. Ignored unless IDLE.
- i_seq_abort  input  1  level; forces return to IDLE on the next edge.
- i_regf_CMD_ATTR  input  1  0 = regular, 1 = immediate.
- i_regf_DATA_LEN  input  LEN_W  byte count for regular commands.
- i_regf_DTT  input  3  byte count for immediate commands; 5-7 are reserved.
- i_bit_tick  input  1  qualifies i_cnt_bit_count; one pulse per DDR bit.
- i_cnt_bit_count  input  6  bit index within the 20-bit word, 0..19.
- o_seq_busy  output  1  high in any state other than IDLE.
- o_byte_strobe  output  1  1-cycle pulse per completed data byte.
- o_last_frame  output  1  high while the final data byte is in flight.
- o_crc_phase  output  1  high during the CRC word.
- o_seq_done  output  1  1-cycle pulse at normal completion.
- o_seq_err  output  1  sticky; set by a reserved DTT, cleared by the next accepted i_seq_start.
- o_bytes_left  output  LEN_W  remaining data bytes.

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Reset has priority over everything, including in mid-transfer.
- Byte boundary (bb): i_bit_tick=1 and i_cnt_bit_count is 9 or 19. All other bit indices are ignored.
- States: IDLE, LOAD, DATA, CRC, DONE.
- IDLE:
  - Stays here until i_seq_start.
  - On start, captures the descriptor into internal registers and clears o_seq_err.
  - Descriptor inputs may change after the start cycle without effect.
- LOAD (1 cycle):
  - Regular command: o_bytes_left = DATA_LEN.
  - Immediate command, DTT 0..4: o_bytes_left = DTT.
  - Immediate command, DTT 5..7: set o_seq_err and go to IDLE. No strobes are issued and o_seq_done is not pulsed.
  - If the count is 0, go to CRC when CRC_WORD_EN=1, otherwise to DONE.
  - Otherwise go to DATA.
- DATA:
  - On each bb: pulse o_byte_strobe in the following cycle (latency 1 clock after the bb) and decrement o_bytes_left.
  - o_last_frame is high whenever o_bytes_left == 1 in DATA.
  - When the decrement reaches 0, go to CRC or DONE.
  - The counter never wraps below 0.
- CRC:
  - o_crc_phase = 1.
  - Exits on the first bb with i_cnt_bit_count == 19 and goes to DONE. A bb at bit 9 does not exit.
- DONE (1 cycle): o_seq_done = 1, then go to IDLE. o_seq_busy drops in the cycle after DONE.
- Abort:
  - i_seq_abort in any non-IDLE state goes to IDLE on the next edge.
  - Clears o_bytes_left, o_last_frame and o_crc_phase.
  - No o_seq_done pulse; o_seq_err is unchanged.
  - Abort has priority over a simultaneous bb.
- i_seq_start while busy is ignored, with no side effects.
- A bb seen in IDLE or LOAD is ignored.
- Arithmetic: unsigned, LEN_W bits. DATA_LEN = 0xFFFF is legal and gives 65535 strobes.

Test Plan:
- Regular, DATA_LEN=4, CRC_WORD_EN=1; drive bb at bits 9, 19, 9, 19, then 19 -> 4 o_byte_strobe pulses, o_bytes_left goes 4→3→2→1→0, o_last_frame high only at 1, o_crc_phase for one word, then o_seq_done.
- Immediate, DTT=3 -> 3 strobes, o_last_frame on the third byte; DTT=0 -> LOAD goes straight to CRC with no strobes.
- Immediate, DTT=6 -> o_seq_err=1, o_seq_busy returns to 0 after LOAD, no strobe, no done; a following valid start clears o_seq_err.
- Abort asserted in DATA with o_bytes_left=2, coincident with a bb -> next cycle IDLE, o_bytes_left=0, no strobe and no done.
- i_cnt_bit_count=9 or 19 with i_bit_tick=0, and other bit indices with i_bit_tick=1 -> no decrement; a second i_seq_start mid-transfer is ignored.
- Async reset pulse in mid-DATA, asserted between clock edges -> all outputs 0 immediately and the state is IDLE.
